// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 weight-address sequencer: default layer
// geometry, FSM state encoding and the ROM address type.
package conv1_pkg;

  localparam int CH         = 3;
  localparam int KH         = 3;
  localparam int KW         = 3;
  localparam int TAPS       = CH * KH * KW;
  localparam int NUM        = 64;
  localparam int ADDR       = 11;
  localparam int OUT_PIXELS = 12321;
  localparam int PIX_W      = 14;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} wgen_state_t;

  typedef logic [ADDR-1:0] rom_addr_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv1_tap_counter.sv
// Nested kernel-tap counter: k (column) fastest, then r (row), then c
// (channel). Keeps a linear tap index alongside so lane addresses need only
// an add, never a multiply. tap_nxt exposes the value the register takes at
// the next edge so the top can register aligned metadata in the same cycle.
module conv1_tap_counter import conv1_pkg::*; #(
  parameter int CH = 3,
  parameter int KH = 3,
  parameter int KW = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            en,
  output logic [$clog2(CH*KH*KW)-1:0]     tap_idx,
  output logic [$clog2(CH*KH*KW)-1:0]     tap_nxt,
  output logic                            wrap
);

  localparam int TAP_W = $clog2(CH * KH * KW);
  localparam int K_W   = cnt_w(KW);
  localparam int R_W   = cnt_w(KH);
  localparam int C_W   = cnt_w(CH);

  logic [K_W-1:0] k_q, k_d;
  logic [R_W-1:0] r_q, r_d;
  logic [C_W-1:0] c_q, c_d;
  logic           k_at, r_at, c_at;

  // Next tap: clear wins, otherwise step k/r/c as a nested odometer.
  always_comb begin
    k_at    = (k_q == K_W'(KW - 1));
    r_at    = (r_q == R_W'(KH - 1));
    c_at    = (c_q == C_W'(CH - 1));
    wrap    = k_at & r_at & c_at;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    tap_nxt = tap_idx;
    if (clr) begin
      k_d     = '0;
      r_d     = '0;
      c_d     = '0;
      tap_nxt = '0;
    end else if (en) begin
      if (wrap) begin
        k_d     = '0;
        r_d     = '0;
        c_d     = '0;
        tap_nxt = '0;
      end else begin
        tap_nxt = tap_idx + TAP_W'(1);
        if (!k_at) begin
          k_d = k_q + K_W'(1);
        end else begin
          k_d = '0;
          if (!r_at) begin
            r_d = r_q + R_W'(1);
          end else begin
            r_d = '0;
            c_d = c_q + C_W'(1);
          end
        end
      end
    end
  end

  // Tap position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      tap_idx <= '0;
    end else begin
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      tap_idx <= tap_nxt;
    end
  end

endmodule

// File: rtl/conv1_weight_addr_gen.sv
// Weight-ROM address sequencer for the first conv layer. Each beat presents
// one kernel tap for all NUM filters in parallel (lane i reads i*TAPS+tap),
// sweeping every tap of every output pixel under valid/ready flow control.
// Optional macro CONV1_WGEN_PERF_CNT_EN adds a saturating stall counter.
module conv1_weight_addr_gen import conv1_pkg::*; #(
  parameter int NUM        = 64,
  parameter int ADDR       = 11,
  parameter int CH         = 3,
  parameter int KH         = 3,
  parameter int KW         = 3,
  parameter int OUT_PIXELS = 12321,
  parameter int PIX_W      = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            out_ready,
  output logic [ADDR-1:0]                 address [0:NUM-1],
  output logic                            addr_valid,
  output logic [$clog2(CH*KH*KW)-1:0]     tap_idx,
  output logic                            first_tap,
  output logic                            last_tap,
  output logic [PIX_W-1:0]                pix_idx,
  output logic                            busy,
  output logic                            done
`ifdef CONV1_WGEN_PERF_CNT_EN
  ,
  output logic [31:0]                     stall_cnt
`endif
);

  localparam int                TAPS     = CH * KH * KW;
  localparam int                TAP_W    = $clog2(TAPS);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(OUT_PIXELS - 1);
  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(TAPS - 1);

  if (NUM * TAPS > 2 ** ADDR) begin : g_bad_addr
    $error("conv1_weight_addr_gen: ADDR too narrow for NUM*TAPS");
  end
  if (OUT_PIXELS > 2 ** PIX_W) begin : g_bad_pix
    $error("conv1_weight_addr_gen: PIX_W too narrow for OUT_PIXELS");
  end

  wgen_state_t       state_q, state_d;
  logic              accept, final_beat;
  logic              vld_p0, busy_p0, done_p0;
  logic [PIX_W-1:0]  pix_p0;
  logic              tap_clr, tap_en, tap_wrap;
  logic [TAP_W-1:0]  tap_nxt;

  assign accept     = addr_valid & out_ready;
  assign final_beat = accept & tap_wrap & (pix_idx == LAST_PIX);

  conv1_tap_counter #(
    .CH (CH),
    .KH (KH),
    .KW (KW)
  ) u_tap (
    .clk     (clk),
    .rst     (rst),
    .clr     (tap_clr),
    .en      (tap_en),
    .tap_idx (tap_idx),
    .tap_nxt (tap_nxt),
    .wrap    (tap_wrap)
  );

  // FSM next state and next values of every registered control output.
  always_comb begin
    state_d = state_q;
    vld_p0  = addr_valid;
    busy_p0 = busy;
    done_p0 = 1'b0;
    pix_p0  = pix_idx;
    tap_clr = 1'b0;
    tap_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vld_p0  = 1'b1;
          busy_p0 = 1'b1;
          pix_p0  = '0;
          tap_clr = 1'b1;
        end
      end
      RUN: begin
        if (final_beat) begin
          // Last tap of last pixel taken: park counters and flag completion.
          state_d = FLUSH;
          vld_p0  = 1'b0;
          done_p0 = 1'b1;
          pix_p0  = '0;
          tap_clr = 1'b1;
        end else if (accept) begin
          tap_en = 1'b1;
          if (tap_wrap) pix_p0 = pix_idx + PIX_W'(1);
        end
      end
      FLUSH: begin
        state_d = IDLE;
        vld_p0  = 1'b0;
        busy_p0 = 1'b0;
      end
      default: begin
        state_d = IDLE;
        vld_p0  = 1'b0;
        busy_p0 = 1'b0;
      end
    endcase
  end

  // State and control output registers (stage p0 -> outputs).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_valid <= 1'b0;
      first_tap  <= 1'b0;
      last_tap   <= 1'b0;
      pix_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_valid <= vld_p0;
      first_tap  <= vld_p0 & (tap_nxt == '0);
      last_tap   <= vld_p0 & (tap_nxt == LAST_TAP);
      pix_idx    <= pix_p0;
      busy       <= busy_p0;
      done       <= done_p0;
    end
  end

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    localparam logic [ADDR-1:0] LANE_OFF = ADDR'(i * TAPS);
    // Lane address: fixed filter base plus the shared tap, registered with it.
    always_ff @(posedge clk) begin
      if (rst) address[i] <= '0;
      else     address[i] <= LANE_OFF + ADDR'(tap_nxt);
    end
  end

`ifdef CONV1_WGEN_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count RUN cycles where a beat is offered but not taken; clear per frame.
  always_ff @(posedge clk) begin
    if (rst)                                       stall_cnt <= '0;
    else if (state_q == IDLE && start)             stall_cnt <= '0;
    else if (state_q == RUN && addr_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`else
`endif

endmodule
